// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM encodings, store-data source selects and limits.
package mem_access_unit_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam logic [1:0] FWD_WDATA = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  localparam int WAIT_MAX = 7;
  localparam int CNT_W = 3;
endpackage

// File: rtl/mem_access_unit_data_ram.sv
// data_ram: single-port DEPTH x WIDTH store, synchronous write, async read and async clear.
module data_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit with wait-stated reads, store forwarding and flush.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int REG_AW = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              halt,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_read,
  input  logic              is_write,
  input  logic              reg_write,
  input  logic [WIDTH-1:0]  base,
  input  logic [WIDTH-1:0]  offset,
  input  logic [REG_AW-1:0] rd,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  exe_result,
  input  logic [1:0]        fwd_sel,
  output logic              wb_valid,
  output logic [WIDTH-1:0]  wb_data,
  output logic [REG_AW-1:0] wb_reg,
  output logic              wb_reg_write,
  output logic              busy,
  output logic              addr_err
);
  localparam int AW = $clog2(DEPTH);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   ea;
  logic [WIDTH-1:0] sd, rdata;
  logic             in_range, accept, we, rw_q;
  // The extra sum bit keeps a wrapped address from aliasing into range.
  assign ea = {1'b0, base} + {1'b0, offset};
  assign in_range = ea < (WIDTH + 1)'(DEPTH);
  assign req_ready = state == ST_IDLE && !halt;
  assign accept = req_valid && req_ready && !flush;
  assign we = accept && is_write && in_range;
  assign sd = fwd_sel == FWD_EXE ? exe_result : fwd_sel == FWD_WB ? wb_data : wdata;
  assign busy = state != ST_IDLE;
  assign wb_valid = state == ST_DONE && !flush;
  assign wb_reg_write = wb_valid && rw_q;
  data_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (ea[AW-1:0]),
    .wdata(sd),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wb_data  <= '0;
      wb_reg   <= '0;
      rw_q     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= accept && (is_read || is_write) && !in_range;
      if (flush && state != ST_IDLE) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (state == ST_IDLE) begin
        if (accept && is_read) begin
          state   <= WAIT_CYCLES == 0 ? ST_DONE : ST_WAIT;
          cnt     <= CNT_W'(WAIT_CYCLES);
          wb_data <= !in_range ? '0 : we ? sd : rdata;
          wb_reg  <= rd;
          rw_q    <= reg_write && in_range;
        end
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) state <= ST_DONE;
      end else begin
        state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit at default parameters.
module tb_mem_access_unit;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, halt = 1'b0, req_valid = 1'b0;
  logic is_read = 1'b0, is_write = 1'b0, reg_write = 1'b0;
  logic [15:0] base = '0, offset = '0, wdata = '0, exe_result = '0;
  logic [3:0] rd = '0;
  logic [1:0] fwd_sel = '0;
  logic req_ready, wb_valid, wb_reg_write, busy, addr_err;
  logic [15:0] wb_data;
  logic [3:0] wb_reg;
  typedef struct {logic [15:0] data; logic [3:0] rg; logic rw; int cyc;} exp_t;
  exp_t sb[$];
  logic [15:0] model [64];
  logic [15:0] last_wb = '0;
  int cyc = 0, checks = 0, failures = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .halt(halt), .req_valid(req_valid),
    .req_ready(req_ready), .is_read(is_read), .is_write(is_write), .reg_write(reg_write),
    .base(base), .offset(offset), .rd(rd), .wdata(wdata), .exe_result(exe_result),
    .fwd_sel(fwd_sel), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_reg_write(wb_reg_write), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (wb_valid !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wb_valid cyc=%0d got wb_valid=%b want 0", cyc, wb_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 4;
        if (wb_data !== e.data) begin failures++; $display("FAIL wb_data got %h want %h", wb_data, e.data); end
        if (wb_reg !== e.rg) begin failures++; $display("FAIL wb_reg got %0d want %0d", wb_reg, e.rg); end
        if (wb_reg_write !== e.rw) begin failures++; $display("FAIL wb_reg_write got %b want %b", wb_reg_write, e.rw); end
        if (cyc != e.cyc) begin failures++; $display("FAIL wb_latency got cyc %0d want %0d", cyc, e.cyc); end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, w, rw, input logic [15:0] b, o, input logic [3:0] d,
                       input logic [15:0] wd, ex, input logic [1:0] fs, input logic acc);
    logic [16:0] s;
    logic [15:0] sdat, rv;
    exp_t e;
    is_read = r; is_write = w; reg_write = rw; base = b; offset = o; rd = d;
    wdata = wd; exe_result = ex; fwd_sel = fs; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; is_read = 1'b0; is_write = 1'b0;
    if (acc) begin
      s = {1'b0, b} + {1'b0, o};
      sdat = fs == 2'b01 ? ex : fs == 2'b10 ? last_wb : wd;
      if (w && s < 64) model[s[5:0]] = sdat;
      if (r) begin
        rv = s < 64 ? model[s[5:0]] : 16'h0;
        last_wb = rv;
        e.data = rv; e.rg = d; e.rw = rw && s < 64; e.cyc = cyc + W;
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 64; i++) model[i] = '0;
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if ({busy, wb_valid, wb_reg_write, addr_err, wb_data, wb_reg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b v=%b rw=%b err=%b data=%h reg=%0d want all 0",
               busy, wb_valid, wb_reg_write, addr_err, wb_data, wb_reg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_store_read;
    issue(0, 1, 0, 3, 2, 0, 16'h1234, 16'h0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if ({busy, wb_valid} !== 2'b00) begin failures++; $display("FAIL store_quiet got busy=%b v=%b want 0 0", busy, wb_valid); end
    @(posedge clk); #1;
    issue(1, 0, 1, 3, 2, 9, 16'h0, 16'h0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL read_busy got %b want 1", busy); end
    idle(W + 3);
  endtask

  task automatic test_forwarding;
    issue(0, 1, 0, 7, 0, 0, 16'h5555, 16'h00AA, 2'b01, 1);
    issue(1, 0, 1, 7, 0, 3, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
    issue(0, 1, 0, 4, 4, 0, 16'h0F0F, 16'hFFFF, 2'b11, 1);
    issue(1, 0, 1, 8, 0, 4, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
    issue(0, 1, 0, 9, 0, 0, 16'h1111, 16'h2222, 2'b10, 1);
    issue(1, 0, 1, 0, 9, 6, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
  endtask

  task automatic test_range;
    issue(1, 0, 1, 60, 4, 5, 16'h0, 16'h0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b1) begin failures++; $display("FAIL rd_addr_err got %b want 1", addr_err); end
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b0) begin failures++; $display("FAIL rd_addr_err_clear got %b want 0", addr_err); end
    idle(W + 2);
    issue(0, 1, 0, 16'hFFFF, 16'h0001, 0, 16'hDEAD, 16'h0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b1) begin failures++; $display("FAIL wr_addr_err got %b want 1", addr_err); end
    @(posedge clk); #1;
    issue(1, 0, 1, 0, 0, 1, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
    issue(0, 1, 0, 62, 1, 0, 16'hCAFE, 16'h0, 2'b00, 1);
    issue(1, 0, 1, 63, 0, 2, 16'h0, 16'h0, 2'b00, 1);
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b0) begin failures++; $display("FAIL edge_addr_err got %b want 0", addr_err); end
    idle(W + 3);
  endtask

  task automatic test_read_write;
    issue(1, 1, 1, 10, 0, 7, 16'hBEEF, 16'h0, 2'b00, 1);
    idle(W + 3);
  endtask

  task automatic test_flush;
    issue(1, 0, 1, 5, 0, 8, 16'h0, 16'h0, 2'b00, 1);
    void'(sb.pop_back());
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, busy} !== 2'b10) begin failures++; $display("FAIL flush_idle got ready=%b busy=%b want 1 0", req_ready, busy); end
    idle(W + 3);
    issue(1, 0, 1, 7, 0, 9, 16'h0, 16'h0, 2'b00, 1);
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_wait_busy got %b want 0", busy); end
    idle(W + 3);
  endtask

  task automatic test_blocked;
    flush = 1'b1;
    issue(0, 1, 0, 5, 0, 0, 16'h9999, 16'h0, 2'b00, 0);
    flush = 1'b0;
    issue(1, 0, 1, 5, 0, 10, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
    halt = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL halt_ready got %b want 0", req_ready); end
    @(posedge clk); #1;
    issue(0, 1, 0, 5, 0, 0, 16'h4444, 16'h0, 2'b00, 0);
    halt = 1'b0;
    issue(1, 0, 1, 5, 0, 11, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
  endtask

  task automatic test_back_to_back;
    int acc_cyc[3];
    int n = 0;
    logic rdy;
    exp_t e;
    is_read = 1'b1; reg_write = 1'b1; base = 0; offset = 7; rd = 12; fwd_sel = 2'b00;
    req_valid = 1'b1;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc_cyc[n] = cyc;
        e.data = model[7]; e.rg = rd; e.rw = 1'b1; e.cyc = cyc + W;
        sb.push_back(e);
        last_wb = model[7];
        rd = rd + 1'b1;
        n++;
      end
    end
    req_valid = 1'b0; is_read = 1'b0;
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b_accepts got %0d want 3", n);
    end else begin
      checks += 2;
      if (acc_cyc[1] - acc_cyc[0] != W + 2) begin failures++; $display("FAIL b2b_gap1 got %0d want %0d", acc_cyc[1] - acc_cyc[0], W + 2); end
      if (acc_cyc[2] - acc_cyc[1] != W + 2) begin failures++; $display("FAIL b2b_gap2 got %0d want %0d", acc_cyc[2] - acc_cyc[1], W + 2); end
    end
    idle(W + 3);
  endtask

  task automatic test_reset_mid;
    issue(0, 1, 0, 12, 0, 0, 16'h7777, 16'h0, 2'b00, 1);
    issue(1, 0, 1, 12, 0, 2, 16'h0, 16'h0, 2'b00, 1);
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, wb_valid, wb_reg_write, addr_err, wb_data, wb_reg} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b v=%b rw=%b err=%b data=%h reg=%0d want all 0",
               busy, wb_valid, wb_reg_write, addr_err, wb_data, wb_reg);
    end
    for (int i = 0; i < 64; i++) model[i] = '0;
    last_wb = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    issue(1, 0, 1, 12, 0, 2, 16'h0, 16'h0, 2'b00, 1);
    idle(W + 3);
  endtask

  initial begin
    test_reset();
    test_store_read();
    test_forwarding();
    test_range();
    test_read_write();
    test_flush();
    test_blocked();
    test_back_to_back();
    test_reset_mid();
    idle(4);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drained got %0d pending want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
